pcie_mem_completer: RTL and testbench
=====================================

PCIE_MEM_COMPLETER -- requirements
Module: pcie_mem_completer

Interface
REQ-001 user_clk  input  1  sole clock; all logic on rising edge.
REQ-002 user_reset  input  1  asynchronous, active-high reset.
REQ-003 m_axis_rx_tdata  input  256  received TLP beat; DW0 at [31:0], DW1 [63:32], DW2 [95:64], DW3 [127:96].
REQ-004 m_axis_rx_tkeep  input  32  byte valid mask; ignored except for framing.
REQ-005 m_axis_rx_tlast  input  1  last beat of TLP.
REQ-006 m_axis_rx_tvalid  input  1  beat valid.
REQ-007 m_axis_rx_tready  output  1  block accepts beat.
REQ-008 s_axis_tx_tdata  output  256  completion TLP beat, same DW layout.
REQ-009 s_axis_tx_tkeep  output  32  byte valid mask of completion.
REQ-010 s_axis_tx_tlast  output  1  always 1 while tx valid (single-beat completions).
REQ-011 s_axis_tx_tvalid  output  1  completion valid.
REQ-012 s_axis_tx_tready  input  1  endpoint accepts completion.
REQ-013 s_axis_tx_tuser  output  4  constant 0.
REQ-014 cfg_completer_id  input  16  bus/dev/func placed in completions.
REQ-015 drop_count  output  16  saturating count of discarded TLPs.

Function
REQ-016 Header decode: fmt=DW0[30:29], type=DW0[28:24], length=DW0[9:0], requester ID=DW1[31:16], tag=DW1[15:8], first BE=DW1[3:0], address=DW2[31:2].
REQ-017 Supported: MRd32 (fmt 00, type 00000) and MWr32 (fmt 10, type 00000) with length 1 and address DW2[31:6]==0; all else unsupported.
REQ-018 Storage: 16 x 32-bit registers indexed by DW2[5:2], reset to 0.
REQ-019 FSM states IDLE, DRAIN, CPL.
REQ-020 IDLE: rx_tready=1; on rx handshake decode first beat; MWr writes DW3 bytes where first BE bit set, same cycle; MRd captures data, tag, requester ID, DW2[6:0]; next state CPL if completion needed and tlast=1, DRAIN if tlast=0, else IDLE.
REQ-021 DRAIN: rx_tready=1; beats discarded; on tlast handshake go to CPL if completion pending else IDLE.
REQ-022 CPL: rx_tready=0; tx_tvalid=1, payload stable until tx_tready; on handshake go to IDLE; tx_tvalid must not drop without handshake.
REQ-023 CplD format: DW0 = 0x4A000001; DW1 = {cfg_completer_id, 3'b000 status, 1'b0, 12'd4}; DW2 = {requester ID, tag, 1'b0, lower addr[6:0]}; DW3 = register data; tkeep=0x0000FFFF; upper DWs 0.
REQ-024 Read data reflects all writes completed before the MRd was accepted.
REQ-025 Completion latency: tx_tvalid asserts the cycle after the MRd last-beat handshake.
REQ-026 Each unsupported TLP without a completion increments drop_count once (at first beat); saturates at 0xFFFF.
REQ-027 MWr with first BE=0 writes nothing and is not dropped.

Reset
REQ-028 On user_reset: FSM=IDLE, rx_tready=0 during reset, tx_tvalid=0, tx_tdata/tkeep=0, tlast=1, drop_count=0, registers=0; a completion in flight is abandoned.
REQ-029 First rx acceptance occurs the first cycle after reset deasserts.

Configuration
REQ-030 Macro PCIE_CPL_UR_EN: when defined, an unsupported MRd32 (length!=1 or out-of-range address) yields Cpl with status UR: DW0=0x0A000000, DW1 status field 3'b001, byte count 0, no DW3, tkeep=0x00000FFF, and is not counted in drop_count; when undefined, it is dropped and counted per REQ-026.

Verification
REQ-031 MWr32 addr 0x14, BE 0xF, data 0xDEADBEEF; then MRd32 addr 0x14 tag 0x07 req ID 0x0100, cfg_completer_id 0x0200 -> CplD DW0 0x4A000001, DW1 0x02000004, DW2 0x01000714, DW3 0xDEADBEEF.
REQ-032 MWr32 BE 0x3 data 0x11223344 onto register holding 0xAAAAAAAA, read back -> DW3 0xAAAA3344.
REQ-033 MRd with tx_tready held 0 for 10 cycles -> tx_tvalid and tdata stable, rx_tready 0 throughout; completion handshakes on cycle tready rises.
REQ-034 Three-beat MWr length 8 -> all beats accepted, no register changes, drop_count=1.
REQ-035 MRd addr 0x100: without PCIE_CPL_UR_EN -> no tx_tvalid, drop_count=1; with it -> Cpl DW0 0x0A000000, status 001, tkeep 0x00000FFF.
REQ-036 Assert user_reset while in CPL -> tx_tvalid 0 asynchronously, drop_count 0, registers read back 0.

Source files
------------

// File: rtl/pcie_mem_completer_if.sv
// AXI-Stream request (rx) and completion (tx) channels of the memory completer.
// A beat transfers on a rising edge where tvalid and tready are both high; a source holds a valid beat stable until that edge.
interface pcie_mem_completer_if;
    logic [255:0] m_axis_rx_tdata;
    logic [31:0]  m_axis_rx_tkeep;
    logic         m_axis_rx_tlast;
    logic         m_axis_rx_tvalid;
    logic         m_axis_rx_tready;
    logic [255:0] s_axis_tx_tdata;
    logic [31:0]  s_axis_tx_tkeep;
    logic         s_axis_tx_tlast;
    logic         s_axis_tx_tvalid;
    logic         s_axis_tx_tready;
    logic [3:0]   s_axis_tx_tuser;

    // Completer side: consumes requests, sources completions.
    modport slave (
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        output m_axis_rx_tready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tuser,
        input  s_axis_tx_tready
    );

    // Endpoint side: sources requests, consumes completions.
    modport master (
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        input  m_axis_rx_tready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tuser,
        output s_axis_tx_tready
    );
endinterface

// File: rtl/pcie_mem_completer.sv
// PCIe MRd32/MWr32 completer backed by a 16 x 32-bit register file; single-beat CplD responses.
// Optional macro PCIE_CPL_UR_EN: unsupported MRd32 gets an Unsupported Request Cpl instead of being dropped.
module pcie_mem_completer (
    input  logic                     user_clk,
    input  logic                     user_reset,
    pcie_mem_completer_if.slave      axis,
    input  logic [15:0]              cfg_completer_id,
    output logic [15:0]              drop_count,
    output logic [1:0]               dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CPL   = 2'd2
    } state_t;

    state_t        state_q;
    logic          pend_q;
    logic [255:0]  tx_data_q;
    logic [31:0]   tx_keep_q;
    logic          tx_valid_q;
    logic [15:0]   drop_q;
    logic [31:0]   regs_q [16];

    logic [31:0] dw0, dw1, dw2, dw3;
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  first_be;
    logic [3:0]  idx;
    logic        is_mrd, is_mwr, shape_ok;
    logic        rx_ready, rx_hs, first_hs, wr_en;
    logic        cpl_ok, cpl_ur, need_cpl, drop_tlp;
    logic [31:0] cpl_dw2;
    logic [255:0] cpl_data;
    logic [31:0]  cpl_keep;

    assign dw0      = axis.m_axis_rx_tdata[31:0];
    assign dw1      = axis.m_axis_rx_tdata[63:32];
    assign dw2      = axis.m_axis_rx_tdata[95:64];
    assign dw3      = axis.m_axis_rx_tdata[127:96];
    assign fmt      = dw0[30:29];
    assign typ      = dw0[28:24];
    assign len      = dw0[9:0];
    assign req_id   = dw1[31:16];
    assign tag      = dw1[15:8];
    assign first_be = dw1[3:0];
    assign idx      = dw2[5:2];

    assign is_mrd   = (fmt == 2'b00) && (typ == 5'd0);
    assign is_mwr   = (fmt == 2'b10) && (typ == 5'd0);
    assign shape_ok = (len == 10'd1) && (dw2[31:6] == 26'd0);

    // Ready is a decode of registered state, forced low while reset is held.
    assign rx_ready = !user_reset && (state_q != ST_CPL);
    assign rx_hs    = axis.m_axis_rx_tvalid && rx_ready;
    assign first_hs = rx_hs && (state_q == ST_IDLE);
    assign wr_en    = first_hs && is_mwr && shape_ok;

    assign cpl_ok = is_mrd && shape_ok;
`ifdef PCIE_CPL_UR_EN
    assign cpl_ur = is_mrd && !shape_ok;
`else
    assign cpl_ur = 1'b0;
`endif
    assign need_cpl = cpl_ok || cpl_ur;
    assign drop_tlp = !(is_mwr && shape_ok) && !need_cpl;

    always_comb begin
        cpl_dw2 = {req_id, tag, 1'b0, dw2[6:0]};
        if (cpl_ur) begin
            cpl_data = {128'd0, 32'd0, cpl_dw2,
                        {cfg_completer_id, 3'b001, 1'b0, 12'd0}, 32'h0A00_0000};
            cpl_keep = 32'h0000_0FFF;
        end else begin
            cpl_data = {128'd0, regs_q[idx], cpl_dw2,
                        {cfg_completer_id, 3'b000, 1'b0, 12'd4}, 32'h4A00_0001};
            cpl_keep = 32'h0000_FFFF;
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (first_be[b]) regs_q[idx][b*8 +: 8] <= dw3[b*8 +: 8];
        end
    end

    // Completion payload is captured at the first beat; DRAIN only waits out trailing beats.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_keep_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (first_hs) begin
                        if (drop_tlp && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
                        if (need_cpl) begin
                            tx_data_q <= cpl_data;
                            tx_keep_q <= cpl_keep;
                        end
                        if (!axis.m_axis_rx_tlast) begin
                            state_q <= ST_DRAIN;
                            pend_q  <= need_cpl;
                        end else if (need_cpl) begin
                            state_q    <= ST_CPL;
                            tx_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rx_hs && axis.m_axis_rx_tlast) begin
                        pend_q <= 1'b0;
                        if (pend_q) begin
                            state_q    <= ST_CPL;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CPL: begin
                    if (axis.s_axis_tx_tready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axis.m_axis_rx_tkeep, axis.m_axis_rx_tdata[255:128],
                         dw0[31], dw0[23:10], dw1[7:4]};

    assign axis.m_axis_rx_tready = rx_ready;
    assign axis.s_axis_tx_tdata  = tx_data_q;
    assign axis.s_axis_tx_tkeep  = tx_keep_q;
    assign axis.s_axis_tx_tlast  = 1'b1;
    assign axis.s_axis_tx_tvalid = tx_valid_q;
    assign axis.s_axis_tx_tuser  = 4'd0;
    assign drop_count            = drop_q;
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_pcie_mem_completer.sv
// Table-driven bench for pcie_mem_completer with a completion scoreboard and multi-cycle corner sequences.
module tb_pcie_mem_completer;
  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic [15:0] cfg_id = 16'h0200;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  pcie_mem_completer_if bus();

  pcie_mem_completer dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .axis             (bus),
    .cfg_completer_id (cfg_id),
    .drop_count       (drop_cnt),
    .dbg_state_o      (dbg_state)
  );

  always #5 user_clk = ~user_clk;

`ifdef PCIE_CPL_UR_EN
  localparam bit UR = 1'b1;
`else
  localparam bit UR = 1'b0;
`endif

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] req;
    int          nbeats;
    bit          cpl;
    bit          ur;
    logic [31:0] dw3;
    int          drop_inc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic [255:0] exp_q [$];
  logic [31:0]  keep_q [$];
  int checks = 0;
  int failures = 0;
  int exp_drop = 0;
  bit tready_auto = 1'b1;
  bit tready_man = 1'b0;

  function automatic vec_t mkv(logic [1:0] fmt, logic [4:0] typ, logic [9:0] len,
                               logic [31:0] addr, logic [3:0] be, logic [31:0] data,
                               logic [7:0] tag, logic [15:0] req, int nbeats,
                               bit cpl, bit ur, logic [31:0] dw3, int drop_inc);
    vec_t v;
    v.fmt = fmt; v.typ = typ; v.len = len; v.addr = addr; v.be = be; v.data = data;
    v.tag = tag; v.req = req; v.nbeats = nbeats; v.cpl = cpl; v.ur = ur; v.dw3 = dw3;
    v.drop_inc = drop_inc;
    return v;
  endfunction

  function automatic logic [255:0] exp_cpl(vec_t v);
    logic [31:0] d0, d1, d2, d3;
    d0 = v.ur ? 32'h0A00_0000 : 32'h4A00_0001;
    d1 = {cfg_id, (v.ur ? 3'b001 : 3'b000), 1'b0, (v.ur ? 12'd0 : 12'd4)};
    d2 = {v.req, v.tag, 1'b0, v.addr[6:0]};
    d3 = v.ur ? 32'd0 : v.dw3;
    return {128'd0, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Single driver of tx_tready: random backpressure or a manual level.
  always @(posedge user_clk) begin
    #1;
    bus.s_axis_tx_tready = tready_auto ? ($urandom_range(0, 3) != 0) : tready_man;
  end

  // Scoreboard monitor: a handshake happens on the next rising edge when both are high here.
  logic         prev_v = 1'b0;
  logic [255:0] prev_d = '0;
  always @(negedge user_clk) begin
    if (user_reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v) begin
        chk("tx_hold_valid", bus.s_axis_tx_tvalid, 1'b1);
        chk("tx_hold_data", bus.s_axis_tx_tdata, prev_d);
      end
      prev_v = bus.s_axis_tx_tvalid && !bus.s_axis_tx_tready;
      prev_d = bus.s_axis_tx_tdata;
      if (bus.s_axis_tx_tvalid && bus.s_axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cpl actual=%0h required=none", bus.s_axis_tx_tdata);
        end else begin
          chk("cpl_tdata", bus.s_axis_tx_tdata, exp_q.pop_front());
          chk("cpl_tkeep", bus.s_axis_tx_tkeep, keep_q.pop_front());
          chk("cpl_tlast", bus.s_axis_tx_tlast, 1'b1);
          chk("cpl_tuser", bus.s_axis_tx_tuser, 4'd0);
        end
      end
    end
  end

  task automatic send_beat(input logic [255:0] d, input logic last);
    int n;
    bus.m_axis_rx_tdata  = d;
    bus.m_axis_rx_tkeep  = 32'h0000_FFFF;
    bus.m_axis_rx_tlast  = last;
    bus.m_axis_rx_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (!bus.m_axis_rx_tready && n < 200);
    if (!bus.m_axis_rx_tready) timeout_fail("rx_accept");
    @(posedge user_clk);
    #1;
    bus.m_axis_rx_tvalid = 1'b0;
  endtask

  task automatic send_tlp(input vec_t v);
    logic [255:0] beat;
    beat = {128'd0, v.data, v.addr, {v.req, v.tag, 4'h0, v.be},
            {1'b0, v.fmt, v.typ, 14'd0, v.len}};
    for (int b = 0; b < v.nbeats; b++) begin
      if (b > 0) beat = {8{$urandom()}};
      send_beat(beat, b == v.nbeats - 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge user_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("cpl_wait");
      exp_q.delete();
      keep_q.delete();
    end
    repeat (4) @(posedge user_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    if (v.cpl) begin
      exp_q.push_back(exp_cpl(v));
      keep_q.push_back(v.ur ? 32'h0000_0FFF : 32'h0000_FFFF);
    end
    exp_drop += v.drop_inc;
    send_tlp(v);
    wait_drain();
    chk({name, "_drop"}, drop_cnt, exp_drop);
    chk({name, "_tx_idle"}, bus.s_axis_tx_tvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va;
    bus.m_axis_rx_tdata  = '0;
    bus.m_axis_rx_tkeep  = '0;
    bus.m_axis_rx_tlast  = 1'b0;
    bus.m_axis_rx_tvalid = 1'b0;

    vecs[0]  = mkv(2'b10, 5'd0, 10'd1, 32'h14,  4'hF, 32'hDEADBEEF, 8'h00, 16'h0000, 1, 0, 0, 32'h0, 0);
    vecs[1]  = mkv(2'b00, 5'd0, 10'd1, 32'h14,  4'hF, 32'h0,        8'h07, 16'h0100, 1, 1, 0, 32'hDEADBEEF, 0);
    vecs[2]  = mkv(2'b10, 5'd0, 10'd1, 32'h20,  4'hF, 32'hAAAAAAAA, 8'h00, 16'h0000, 1, 0, 0, 32'h0, 0);
    vecs[3]  = mkv(2'b10, 5'd0, 10'd1, 32'h20,  4'h3, 32'h11223344, 8'h00, 16'h0000, 1, 0, 0, 32'h0, 0);
    vecs[4]  = mkv(2'b00, 5'd0, 10'd1, 32'h20,  4'hF, 32'h0,        8'h11, 16'h0ABC, 1, 1, 0, 32'hAAAA3344, 0);
    vecs[5]  = mkv(2'b10, 5'd0, 10'd8, 32'h08,  4'hF, 32'h55555555, 8'h00, 16'h0000, 3, 0, 0, 32'h0, 1);
    vecs[6]  = mkv(2'b00, 5'd0, 10'd1, 32'h08,  4'hF, 32'h0,        8'h22, 16'h1234, 1, 1, 0, 32'h0, 0);
    vecs[7]  = mkv(2'b00, 5'd0, 10'd1, 32'h100, 4'hF, 32'h0,        8'h33, 16'h0100, 1, UR, UR, 32'h0, UR ? 0 : 1);
    vecs[8]  = mkv(2'b10, 5'd0, 10'd1, 32'h14,  4'h0, 32'hFFFFFFFF, 8'h00, 16'h0000, 1, 0, 0, 32'h0, 0);
    vecs[9]  = mkv(2'b00, 5'd0, 10'd1, 32'h14,  4'hF, 32'h0,        8'h44, 16'h0100, 2, 1, 0, 32'hDEADBEEF, 0);
    vecs[10] = mkv(2'b10, 5'b00100, 10'd1, 32'h14, 4'hF, 32'h0,     8'h00, 16'h0000, 1, 0, 0, 32'h0, 1);
    vecs[11] = mkv(2'b00, 5'd0, 10'd2, 32'h14,  4'hF, 32'h0,        8'h55, 16'h0100, 1, UR, UR, 32'h0, UR ? 0 : 1);
    vecs[12] = mkv(2'b10, 5'd0, 10'd1, 32'h3C,  4'hC, 32'h12345678, 8'h00, 16'h0000, 1, 0, 0, 32'h0, 0);
    vecs[13] = mkv(2'b00, 5'd0, 10'd1, 32'h3C,  4'hF, 32'h0,        8'h66, 16'hFFFF, 1, 1, 0, 32'h12340000, 0);
    vecs[14] = mkv(2'b01, 5'd0, 10'd1, 32'h14,  4'hF, 32'h0,        8'h77, 16'h0100, 1, 0, 0, 32'h0, 1);
    vecs[15] = mkv(2'b10, 5'd0, 10'd1, 32'h3C,  4'hF, 32'hCAFEF00D, 8'h00, 16'h0000, 2, 0, 0, 32'h0, 0);
    vecs[16] = mkv(2'b00, 5'd0, 10'd1, 32'h3C,  4'hF, 32'h0,        8'h88, 16'h0100, 1, 1, 0, 32'hCAFEF00D, 0);
    vecs[17] = mkv(2'b00, 5'd0, 10'd1, 32'h40,  4'hF, 32'h0,        8'h99, 16'h0100, 3, UR, UR, 32'h0, UR ? 0 : 1);

    // Reset state.
    repeat (3) @(negedge user_clk);
    chk("rst_tx_valid", bus.s_axis_tx_tvalid, 1'b0);
    chk("rst_rx_ready", bus.m_axis_rx_tready, 1'b0);
    chk("rst_tx_data", bus.s_axis_tx_tdata, 256'd0);
    chk("rst_tx_keep", bus.s_axis_tx_tkeep, 32'd0);
    chk("rst_tx_last", bus.s_axis_tx_tlast, 1'b1);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    @(negedge user_clk);
    chk("rst_first_ready", bus.m_axis_rx_tready, 1'b1);
    @(posedge user_clk);
    #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("row%0d", i));

    // Backpressure: completion appears one cycle after the MRd and holds for 10 cycles.
    tready_auto = 1'b0;
    tready_man = 1'b0;
    va = mkv(2'b00, 5'd0, 10'd1, 32'h20, 4'hF, 32'h0, 8'hA5, 16'h0100, 1, 1, 0, 32'hAAAA3344, 0);
    exp_q.push_back(exp_cpl(va));
    keep_q.push_back(32'h0000_FFFF);
    send_tlp(va);
    @(negedge user_clk);
    chk("bp_latency_valid", bus.s_axis_tx_tvalid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid_%0d", k), bus.s_axis_tx_tvalid, 1'b1);
      chk($sformatf("bp_data_%0d", k), bus.s_axis_tx_tdata, (exp_q.size() != 0) ? exp_q[0] : 256'd0);
      chk($sformatf("bp_rx_ready_%0d", k), bus.m_axis_rx_tready, 1'b0);
      @(negedge user_clk);
    end
    tready_man = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    chk("bp_released_valid", bus.s_axis_tx_tvalid, 1'b0);
    chk("bp_queue_empty", exp_q.size(), 0);
    @(posedge user_clk);
    #1;

    // Reset while a completion is waiting.
    tready_man = 1'b0;
    va = mkv(2'b00, 5'd0, 10'd1, 32'h14, 4'hF, 32'h0, 8'hAB, 16'h0100, 1, 0, 0, 32'h0, 0);
    send_tlp(va);
    @(negedge user_clk);
    chk("rc_valid_before", bus.s_axis_tx_tvalid, 1'b1);
    #2;
    user_reset = 1'b1;
    #1;
    chk("rc_async_valid", bus.s_axis_tx_tvalid, 1'b0);
    chk("rc_drop", drop_cnt, 16'd0);
    chk("rc_rx_ready", bus.m_axis_rx_tready, 1'b0);
    exp_drop = 0;
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    tready_auto = 1'b1;
    @(negedge user_clk);
    chk("rc_first_ready", bus.m_axis_rx_tready, 1'b1);
    @(posedge user_clk);
    #1;
    run_vec(mkv(2'b00, 5'd0, 10'd1, 32'h14, 4'hF, 32'h0, 8'hB1, 16'h0100, 1, 1, 0, 32'h0, 0), "rc_rd14");
    run_vec(mkv(2'b00, 5'd0, 10'd1, 32'h20, 4'hF, 32'h0, 8'hB2, 16'h0100, 1, 1, 0, 32'h0, 0), "rc_rd20");
    run_vec(mkv(2'b00, 5'd0, 10'd1, 32'h3C, 4'hF, 32'h0, 8'hB3, 16'h0100, 1, 1, 0, 32'h0, 0), "rc_rd3c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
